// File: rtl/baud_tick_if.sv
// Port bundle for baud_tick_gen: rate controls in, tick pulses and debug state out.
// Signalling: no valid/ready handshake is involved. Every input is sampled on each
// rising clk edge. Every tick output is a registered pulse that is high for exactly
// one cycle per event. dbg_acc and dbg_os_cnt mirror the internal phase and
// oversample-count registers so that checkers can bind to them.
interface baud_tick_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 4
);
    logic             en;
    logic [3:0]       baud_sel;
    logic [ACC_W-1:0] cfg_inc;
    logic             resync;
    logic             os_tick;
    logic             bit_tick;
    logic             mid_tick;
    logic             sel_err;
    logic [ACC_W-1:0] dbg_acc;
    logic [CNT_W-1:0] dbg_os_cnt;

    modport master (
        output en, baud_sel, cfg_inc, resync,
        input  os_tick, bit_tick, mid_tick, sel_err, dbg_acc, dbg_os_cnt
    );

    modport slave (
        input  en, baud_sel, cfg_inc, resync,
        output os_tick, bit_tick, mid_tick, sel_err, dbg_acc, dbg_os_cnt
    );
endinterface

// File: rtl/baud_tick_gen.sv
// Phase-accumulator baud tick generator. A table of phase increments is built at
// elaboration from CLK_FREQ and OVERSAMPLE. The carry out of the accumulator gives
// the oversample tick. A small counter derives the bit-boundary and bit-centre ticks.
module baud_tick_gen #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int ACC_W      = 24
) (
    input logic        clk,
    input logic        rst,
    baud_tick_if.slave bus
);

    localparam int               CNT_W      = $clog2(OVERSAMPLE);
    localparam logic [3:0]       SEL_CUSTOM = 4'd13;
    localparam logic [3:0]       SEL_LAST   = 4'd12;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(OVERSAMPLE / 2 - 1);

    // Rounded increment for table entry k. 64-bit math keeps the full product.
    // Entries 13..15 are not table rates and return 0.
    function automatic logic [63:0] table_inc(input int k);
        logic [63:0] baud;
        case (k)
            0:       baud = 64'd1200;
            1:       baud = 64'd2400;
            2:       baud = 64'd4800;
            3:       baud = 64'd9600;
            4:       baud = 64'd19200;
            5:       baud = 64'd28800;
            6:       baud = 64'd38400;
            7:       baud = 64'd57600;
            8:       baud = 64'd76800;
            9:       baud = 64'd115200;
            10:      baud = 64'd230400;
            11:      baud = 64'd460800;
            12:      baud = 64'd921600;
            default: baud = 64'd0;
        endcase
        table_inc = (baud * 64'(OVERSAMPLE) * (64'd1 << ACC_W) + 64'(CLK_FREQ / 2))
                    / 64'(CLK_FREQ);
    endfunction

    localparam logic [63:0] INC_TAB [16] = '{
        table_inc(0),  table_inc(1),  table_inc(2),  table_inc(3),
        table_inc(4),  table_inc(5),  table_inc(6),  table_inc(7),
        table_inc(8),  table_inc(9),  table_inc(10), table_inc(11),
        table_inc(12), table_inc(13), table_inc(14), table_inc(15)
    };

    logic [3:0]       sel_q,      sel_d;
    logic [ACC_W-1:0] acc_q,      acc_d;
    logic [CNT_W-1:0] os_cnt_q,   os_cnt_d;
    logic             os_tick_q,  os_tick_d;
    logic             bit_tick_q, bit_tick_d;
    logic             mid_tick_q, mid_tick_d;
    logic             sel_err_q,  sel_err_d;

    logic [ACC_W-1:0] inc_sel;
    logic             sel_valid;
    logic [ACC_W:0]   sum;
    logic             restart;

    // Increment and validity for the registered selection. A table rate is invalid
    // when its increment does not fit ACC_W bits. A custom rate is invalid when it is zero.
    always_comb begin
        inc_sel   = INC_TAB[sel_q][ACC_W-1:0];
        sel_valid = (sel_q <= SEL_LAST) && ((INC_TAB[sel_q] >> ACC_W) == 64'd0);
        if (sel_q == SEL_CUSTOM) begin
            inc_sel   = bus.cfg_inc;
            sel_valid = |bus.cfg_inc;
        end
    end

    assign sum     = {1'b0, acc_q} + {1'b0, inc_sel};
    // A new rate selection restarts the bit timing exactly as an explicit resync does.
    assign restart = bus.resync | (bus.baud_sel != sel_q);

    // Next state: restart or error clears the phase, an enabled valid add advances it,
    // anything else holds. Ticks default low, so gaps and restarts never emit a pulse.
    always_comb begin
        acc_d      = acc_q;
        os_cnt_d   = os_cnt_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        mid_tick_d = 1'b0;
        sel_d      = bus.baud_sel;
        sel_err_d  = ~sel_valid;
        if (restart || sel_err_q) begin
            acc_d    = '0;
            os_cnt_d = '0;
        end else if (bus.en && sel_valid) begin
            acc_d = sum[ACC_W-1:0];
            if (sum[ACC_W]) begin
                os_tick_d  = 1'b1;
                bit_tick_d = (os_cnt_q == CNT_LAST);
                mid_tick_d = (os_cnt_q == CNT_MID);
                os_cnt_d   = (os_cnt_q == CNT_LAST) ? '0 : os_cnt_q + 1'b1;
            end
        end
    end

    // State registers. Reset captures the live selection so release causes no restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q      <= bus.baud_sel;
            acc_q      <= '0;
            os_cnt_q   <= '0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
            mid_tick_q <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            acc_q      <= acc_d;
            os_cnt_q   <= os_cnt_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
            mid_tick_q <= mid_tick_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign bus.os_tick    = os_tick_q;
    assign bus.bit_tick   = bit_tick_q;
    assign bus.mid_tick   = mid_tick_q;
    assign bus.sel_err    = sel_err_q;
    assign bus.dbg_acc    = acc_q;
    assign bus.dbg_os_cnt = os_cnt_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen at default parameters: directed timing checks plus a
// randomized run, with a per-cycle reference model of phase and tick counts.
module tb_baud_tick_gen;

    localparam int       ACC_W = 24;
    localparam int       OS    = 16;
    localparam longint   MOD   = 64'd1 << ACC_W;

    logic clk;
    logic rst;

    baud_tick_if #(.ACC_W(ACC_W), .CNT_W(4)) bif ();

    baud_tick_gen #(
        .CLK_FREQ  (50_000_000),
        .OVERSAMPLE(OS),
        .ACC_W     (ACC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int bauds [13] = '{1200, 2400, 4800, 9600, 19200, 28800, 38400, 57600,
                       76800, 115200, 230400, 460800, 921600};

    function automatic longint ref_inc(input int sel, input longint cfg);
        if (sel == 13) return cfg;
        if (sel > 12) return 0;
        return (longint'(bauds[sel]) * OS * MOD + 25_000_000) / 50_000_000;
    endfunction

    function automatic bit ref_valid(input int sel, input longint cfg);
        if (sel == 13) return cfg != 0;
        if (sel > 12) return 1'b0;
        return ref_inc(sel, cfg) < MOD;
    endfunction

    // Model: total phase added since the last restart; every whole 2^ACC_W of phase
    // is one oversample tick. Tick number n is a bit centre when n mod 16 = 8 and a
    // bit boundary when n mod 16 = 0.
    int     m_sel;
    bit     m_err;
    longint m_total;
    longint m_wraps;
    bit     e_os, e_bit, e_mid;

    always @(posedge clk) begin
        e_os  = 1'b0;
        e_bit = 1'b0;
        e_mid = 1'b0;
        if (rst) begin
            m_sel   = int'(bif.baud_sel);
            m_err   = 1'b0;
            m_total = 0;
            m_wraps = 0;
        end else begin
            bit v;
            v = ref_valid(m_sel, longint'(bif.cfg_inc));
            if (bif.resync || int'(bif.baud_sel) != m_sel || m_err) begin
                m_total = 0;
                m_wraps = 0;
            end else if (bif.en && v) begin
                m_total += ref_inc(m_sel, longint'(bif.cfg_inc));
                if ((m_total / MOD) > m_wraps) begin
                    m_wraps = m_total / MOD;
                    e_os    = 1'b1;
                    e_mid   = (m_wraps % OS) == OS / 2;
                    e_bit   = (m_wraps % OS) == 0;
                end
            end
            m_err = ~v;
            m_sel = int'(bif.baud_sel);
        end
        #1;
        chk("os_tick",  longint'(bif.os_tick),    longint'(e_os));
        chk("bit_tick", longint'(bif.bit_tick),   longint'(e_bit));
        chk("mid_tick", longint'(bif.mid_tick),   longint'(e_mid));
        chk("sel_err",  longint'(bif.sel_err),    longint'(m_err));
        chk("acc",      longint'(bif.dbg_acc),    m_total % MOD);
        chk("os_cnt",   longint'(bif.dbg_os_cnt), m_wraps % OS);
    end

    // ---------------- driver tasks ----------------
    function automatic logic sig(input int which);
        case (which)
            0:       return bif.os_tick;
            1:       return bif.mid_tick;
            default: return bif.bit_tick;
        endcase
    endfunction

    // Counts edges until the chosen tick is seen; -1 on budget expiry.
    task automatic wait_sig(input int which, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(which) && n < budget);
        if (!sig(which)) n = -1;
    endtask

    task automatic pulse_resync();
        @(negedge clk);
        bif.resync = 1'b1;
        @(negedge clk);
        bif.resync = 1'b0;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int n, c, osn, bitn, ticks;
        rst          = 1'b1;
        bif.en       = 1'b1;
        bif.baud_sel = 4'd13;
        bif.cfg_inc  = 24'h40_0000;
        bif.resync   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sel_err", longint'(bif.sel_err), 0);
        chk("rst_acc", longint'(bif.dbg_acc), 0);
        rst = 1'b0;

        // Custom inc 2^22: os every 4 edges, mid at 32, bit at 64 and 128.
        pulse_resync();
        wait_sig(0, 100, n);  c = n;      chk("first_os", c, 4);
        wait_sig(1, 100, n);  c += n;     chk("first_mid", c, 32);
        wait_sig(2, 100, n);  c += n;     chk("first_bit", c, 64);
        wait_sig(2, 100, n);  c += n;     chk("second_bit", c, 128);

        // Enable gap of 10 cycles after the first os_tick delays everything by 10.
        pulse_resync();
        wait_sig(0, 100, n);  c = n;
        bif.en = 1'b0;
        ticks  = 0;
        repeat (10) begin
            @(negedge clk);
            ticks += int'(bif.os_tick) + int'(bif.bit_tick) + int'(bif.mid_tick);
        end
        bif.en = 1'b1;
        c += 10;
        chk("gap_ticks", ticks, 0);
        wait_sig(0, 100, n);  c += n;     chk("gap_os", c, 18);
        wait_sig(1, 100, n);  c += n;     chk("gap_mid", c, 42);
        wait_sig(2, 100, n);  c += n;     chk("gap_bit", c, 74);

        // 9600: selection change restarts; first os after ceil(2^24/51540)=326 edges.
        @(negedge clk);
        bif.baud_sel = 4'd3;
        @(negedge clk);
        wait_sig(0, 1000, n);             chk("os_9600_first", n, 326);

        // Rate over 40000 edges: floor(40000*51540/2^24)=122 os, 7 bits.
        pulse_resync();
        osn  = 0;
        bitn = 0;
        repeat (40000) begin
            @(negedge clk);
            osn  += int'(bif.os_tick);
            bitn += int'(bif.bit_tick);
        end
        chk("os_rate_9600", osn, 122);
        chk("bit_rate_9600", bitn, 7);

        // Mid-bit change 3 -> 9: clean restart, next bit_tick after 16 os at 115200.
        bif.baud_sel = 4'd9;
        @(negedge clk);
        chk("chg_os", longint'(bif.os_tick), 0);
        chk("chg_acc", longint'(bif.dbg_acc), 0);
        chk("chg_cnt", longint'(bif.dbg_os_cnt), 0);
        n   = 0;
        osn = 0;
        do begin
            @(negedge clk);
            n++;
            osn += int'(bif.os_tick);
        end while (!bif.bit_tick && n < 2000);
        chk("chg_bit_edges", n, 435);
        chk("chg_bit_os", osn, 16);

        // Invalid selections.
        bif.baud_sel = 4'd14;
        repeat (2) @(negedge clk);
        chk("err_sel14", longint'(bif.sel_err), 1);
        bif.baud_sel = 4'd13;
        bif.cfg_inc  = '0;
        repeat (2) @(negedge clk);
        chk("err_cfg0", longint'(bif.sel_err), 1);
        ticks = 0;
        repeat (1000) begin
            @(negedge clk);
            ticks += int'(bif.os_tick) + int'(bif.bit_tick) + int'(bif.mid_tick);
        end
        chk("err_no_ticks", ticks, 0);
        bif.cfg_inc = 24'h40_0000;
        @(negedge clk);
        chk("err_clear", longint'(bif.sel_err), 0);
        wait_sig(0, 100, n);              chk("err_resume_os", n, 4);
        chk("err_resume_cnt", longint'(bif.dbg_os_cnt), 1);

        // Reset coincident with resync and a selection change: no restart afterwards.
        repeat (7) @(negedge clk);
        rst          = 1'b1;
        bif.resync   = 1'b1;
        bif.baud_sel = 4'd3;
        @(negedge clk);
        rst        = 1'b0;
        bif.resync = 1'b0;
        chk("rst_os", longint'(bif.os_tick) + longint'(bif.bit_tick) + longint'(bif.mid_tick), 0);
        chk("rst_err", longint'(bif.sel_err), 0);
        chk("rst_acc2", longint'(bif.dbg_acc), 0);
        @(negedge clk);
        chk("rst_no_restart_acc", longint'(bif.dbg_acc), 51540);

        // Randomized run; the per-cycle model checks every output.
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            bif.en     = ($urandom_range(0, 19) != 0);
            bif.resync = ($urandom_range(0, 299) == 0);
            rst        = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 499) == 0) begin
                if ($urandom_range(0, 3) == 0) bif.baud_sel = 4'($urandom_range(0, 15));
                else                           bif.baud_sel = 4'($urandom_range(7, 13));
            end
            if ($urandom_range(0, 199) == 0) begin
                if ($urandom_range(0, 9) == 0) bif.cfg_inc = '0;
                else bif.cfg_inc = 24'($urandom_range(32'h1_0000, 32'h80_0000));
            end
        end
        @(negedge clk);
        rst        = 1'b0;
        bif.resync = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
